// File: rtl/wb_drain_queue_pkg.sv
// Shared types for the writeback drain queue: queued entry layout and port count.
package wb_pkg;
  localparam int WB_XLEN = 32;
  localparam int WB_PORTS = 2;

  typedef struct packed {
    logic [4:0]         idx;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin grant of up to two requesters per cycle, bounded by a slot limit.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_FU = 4,
  localparam int SW = $clog2(NUM_FU)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_FU-1:0]                req,
  input  logic [1:0]                       limit,
  output logic [NUM_FU-1:0]                grant,
  output logic [WB_PORTS-1:0]              gnt_vld,
  output logic [WB_PORTS-1:0][SW-1:0]      gnt_fu
);

  logic [SW-1:0] rr_ptr, rr_next, last, i;
  logic [SW:0]   s, last_inc;
  logic [1:0]    n;

  // gnt_fu[0] is the older grant (first in scan order from rr_ptr)
  always_comb begin
    grant   = '0;
    gnt_vld = '0;
    gnt_fu  = '0;
    n       = '0;
    last    = rr_ptr;
    s       = '0;
    i       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      s = {1'b0, rr_ptr} + (SW+1)'(k);
      if (s >= (SW+1)'(NUM_FU)) s = s - (SW+1)'(NUM_FU);
      i = s[SW-1:0];
      if (req[i] && (n < limit)) begin
        grant[i] = 1'b1;
        if (n == 2'd0) begin
          gnt_vld[0] = 1'b1;
          gnt_fu[0]  = i;
        end else begin
          gnt_vld[1] = 1'b1;
          gnt_fu[1]  = i;
        end
        last = i;
        n    = n + 2'd1;
      end
    end
  end

  assign last_inc = {1'b0, last} + (SW+1)'(1);
  assign rr_next  = (last_inc >= (SW+1)'(NUM_FU)) ? '0 : last_inc[SW-1:0];

  always_ff @(posedge clock) begin
    if (!reset_n)      rr_ptr <= '0;
    else if (|gnt_vld) rr_ptr <= rr_next;
  end

endmodule

// File: rtl/wb_drain_queue.sv
// Buffers FU writeback results in order and drains up to two per cycle to the
// register file, coalescing adjacent same-register writes and dropping r0.
module wb_drain_queue
  import wb_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 8,
  parameter int XLEN   = WB_XLEN   // must match the package entry width
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][4:0]         fu_idx,
  input  logic [NUM_FU-1:0][XLEN-1:0]    fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic                           flush,
  output logic                           write_en_1,
  output logic                           write_en_2,
  output logic [4:0]                     write_idx_1,
  output logic [4:0]                     write_idx_2,
  output logic [XLEN-1:0]                write_data_1,
  output logic [XLEN-1:0]                write_data_2,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NUM_FU);

  wb_entry_t                      mem [DEPTH];
  logic [PW-1:0]                  head, tail, tail2;
  logic [CW-1:0]                  free;
  logic [1:0]                     limit, enq, pop;
  logic [WB_PORTS-1:0]            gnt_vld;
  logic [WB_PORTS-1:0][SW-1:0]    gnt_fu;
  logic                           e0, e1;
  wb_entry_t                      ent_a, ent_b, hd0, hd1;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign free  = CW'(DEPTH) - count;

  // Slot credit comes from start-of-cycle occupancy only; same-cycle pops don't count.
  always_comb begin
    limit = 2'd0;
    if (reset_n && !flush && !full)
      limit = (free >= CW'(2)) ? 2'd2 : free[1:0];
  end

  wb_rr_arbiter #(.NUM_FU(NUM_FU)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (fu_valid),
    .limit   (limit),
    .grant   (fu_ready),
    .gnt_vld (gnt_vld),
    .gnt_fu  (gnt_fu)
  );

  // r0 writes are accepted from the FU but never occupy a slot
  always_comb begin
    ent_a.idx  = fu_idx[gnt_fu[0]];
    ent_a.data = fu_data[gnt_fu[0]];
    ent_b.idx  = fu_idx[gnt_fu[1]];
    ent_b.data = fu_data[gnt_fu[1]];
    e0         = gnt_vld[0] && (ent_a.idx != 5'd0);
    e1         = gnt_vld[1] && (ent_b.idx != 5'd0);
    enq        = {1'b0, e0} + {1'b0, e1};
    tail2      = tail + PW'(e0);
  end

  assign hd0 = mem[head];
  assign hd1 = mem[head + PW'(1)];

  always_comb begin
    write_en_1   = 1'b0;
    write_idx_1  = '0;
    write_data_1 = '0;
    write_en_2   = 1'b0;
    write_idx_2  = '0;
    write_data_2 = '0;
    pop          = 2'd0;
    if (reset_n && count == CW'(1)) begin
      write_en_1   = 1'b1;
      write_idx_1  = hd0.idx;
      write_data_1 = hd0.data;
      pop          = 2'd1;
    end else if (reset_n && count >= CW'(2)) begin
      pop = 2'd2;
      if (hd0.idx == hd1.idx) begin
        // same register back to back: only the younger value matters
        write_en_1   = 1'b1;
        write_idx_1  = hd1.idx;
        write_data_1 = hd1.data;
      end else begin
        write_en_1   = 1'b1;
        write_idx_1  = hd0.idx;
        write_data_1 = hd0.data;
        write_en_2   = 1'b1;
        write_idx_2  = hd1.idx;
        write_data_2 = hd1.data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && !flush) begin
      if (e0) mem[tail]  <= ent_a;
      if (e1) mem[tail2] <= ent_b;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(enq);
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) count <= CW'(DEPTH));

endmodule

// File: tb/tb_wb_drain_queue.sv
// Bench for wb_drain_queue: directed vector table, hand sequences, and random
// traffic checked every cycle against a queue-based reference model.
module tb_wb_drain_queue;
  import wb_pkg::*;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 8;
  localparam int XLEN   = 32;

  logic                        clock = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        flush = 1'b0;
  logic [NUM_FU-1:0]           fu_valid = '0;
  logic [NUM_FU-1:0][4:0]      fu_idx = '0;
  logic [NUM_FU-1:0][XLEN-1:0] fu_data = '0;
  logic [NUM_FU-1:0]           fu_ready;
  logic                        write_en_1, write_en_2, full, empty;
  logic [4:0]                  write_idx_1, write_idx_2;
  logic [XLEN-1:0]             write_data_1, write_data_2;
  logic [3:0]                  count;

  wb_drain_queue #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .fu_valid(fu_valid), .fu_idx(fu_idx),
    .fu_data(fu_data), .fu_ready(fu_ready), .flush(flush),
    .write_en_1(write_en_1), .write_en_2(write_en_2),
    .write_idx_1(write_idx_1), .write_idx_2(write_idx_2),
    .write_data_1(write_data_1), .write_data_2(write_data_2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: in-order list of pending writes
  typedef struct { logic [4:0] idx; logic [31:0] data; } ment_t;
  ment_t mq[$];
  int    m_rr = 0;

  task automatic model_grant(input logic [3:0] v, output logic [3:0] gm,
                             output int g0, output int g1, output int ng);
    int lim, sz, i;
    sz = mq.size();
    gm = '0; g0 = 0; g1 = 0; ng = 0;
    if (!reset_n || flush || sz >= DEPTH) lim = 0;
    else lim = (DEPTH - sz < 2) ? DEPTH - sz : 2;
    for (int k = 0; k < NUM_FU; k++) begin
      i = (m_rr + k) % NUM_FU;
      if (v[i] && ng < lim) begin
        gm[i] = 1'b1;
        if (ng == 0) g0 = i; else g1 = i;
        ng++;
      end
    end
  endtask

  always @(posedge clock) begin : model_step
    logic [3:0] gm;
    int g0, g1, ng, n;
    if (!reset_n) begin
      mq.delete();
      m_rr = 0;
    end else begin
      model_grant(fu_valid, gm, g0, g1, ng);
      if (flush) mq.delete();
      else begin
        n = mq.size();
        if (n >= 1) void'(mq.pop_front());
        if (n >= 2) void'(mq.pop_front());
        if (ng >= 1 && fu_idx[g0] != 5'd0) mq.push_back('{idx: fu_idx[g0], data: fu_data[g0]});
        if (ng >= 2 && fu_idx[g1] != 5'd0) mq.push_back('{idx: fu_idx[g1], data: fu_data[g1]});
      end
      if (ng > 0) m_rr = ((ng == 2 ? g1 : g0) + 1) % NUM_FU;
    end
  end

  task automatic check_model();
    logic [3:0] gm;
    int g0, g1, ng, sz;
    logic we1, we2;
    logic [4:0] i1, i2;
    logic [31:0] d1, d2;
    model_grant(fu_valid, gm, g0, g1, ng);
    sz = mq.size();
    we1 = 0; we2 = 0; i1 = 0; i2 = 0; d1 = 0; d2 = 0;
    if (reset_n && sz == 1) begin
      we1 = 1; i1 = mq[0].idx; d1 = mq[0].data;
    end else if (reset_n && sz >= 2) begin
      if (mq[0].idx == mq[1].idx) begin
        we1 = 1; i1 = mq[1].idx; d1 = mq[1].data;
      end else begin
        we1 = 1; i1 = mq[0].idx; d1 = mq[0].data;
        we2 = 1; i2 = mq[1].idx; d2 = mq[1].data;
      end
    end
    chk("m_ready", fu_ready, gm);
    chk("m_we1", write_en_1, we1);
    chk("m_idx1", write_idx_1, i1);
    chk("m_data1", write_data_1, d1);
    chk("m_we2", write_en_2, we2);
    if (we2) begin
      chk("m_idx2", write_idx_2, i2);
      chk("m_data2", write_data_2, d2);
    end
    chk("m_count", count, sz);
    chk("m_empty", empty, sz == 0);
    chk("m_full", full, sz == DEPTH);
  endtask

  // drive one cycle's inputs just after the edge; outputs are sampled mid-cycle
  task automatic cyc(input logic rst, input logic [3:0] v, input logic [19:0] ix,
                     input logic [127:0] d, input logic fl);
    @(posedge clock);
    #1;
    reset_n  = rst;
    fu_valid = v;
    fu_idx   = ix;
    fu_data  = d;
    flush    = fl;
    #4;
  endtask

  function automatic logic [19:0] ix4(input int a0, a1, a2, a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic [19:0] ix;
    logic [3:0]  rdy;
    logic        we1;
    logic [4:0]  i1;
    logic        we2;
    logic [4:0]  i2;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[16];
  logic [127:0] tdat;

  initial begin
    tdat = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tbl[0]  = '{4'b0000, ix4(0,0,0,0),     4'b0000, 0, 0,  0, 0,  0};
    tbl[1]  = '{4'b1111, ix4(1,2,3,4),     4'b0011, 0, 0,  0, 0,  0};
    tbl[2]  = '{4'b1111, ix4(1,2,3,4),     4'b1100, 1, 1,  1, 2,  2};
    tbl[3]  = '{4'b0000, ix4(0,0,0,0),     4'b0000, 1, 3,  1, 4,  2};
    tbl[4]  = '{4'b0000, ix4(0,0,0,0),     4'b0000, 0, 0,  0, 0,  0};
    tbl[5]  = '{4'b0011, ix4(7,7,0,0),     4'b0011, 0, 0,  0, 0,  0};
    tbl[6]  = '{4'b0000, ix4(0,0,0,0),     4'b0000, 1, 7,  0, 0,  2};
    tbl[7]  = '{4'b0001, ix4(0,0,0,0),     4'b0001, 0, 0,  0, 0,  0};
    tbl[8]  = '{4'b0000, ix4(0,0,0,0),     4'b0000, 0, 0,  0, 0,  0};
    tbl[9]  = '{4'b1111, ix4(9,10,11,12),  4'b0110, 0, 0,  0, 0,  0};
    tbl[10] = '{4'b0000, ix4(0,0,0,0),     4'b0000, 1, 10, 1, 11, 2};
    tbl[11] = '{4'b0000, ix4(0,0,0,0),     4'b0000, 0, 0,  0, 0,  0};
    tbl[12] = '{4'b0111, ix4(5,5,5,0),     4'b0011, 0, 0,  0, 0,  0};
    tbl[13] = '{4'b0100, ix4(0,0,5,0),     4'b0100, 1, 5,  0, 0,  2};
    tbl[14] = '{4'b0000, ix4(0,0,0,0),     4'b0000, 1, 5,  0, 0,  1};
    tbl[15] = '{4'b0000, ix4(0,0,0,0),     4'b0000, 0, 0,  0, 0,  0};

    // reset held two cycles with requests pending: nothing may be accepted
    cyc(0, 4'b1111, ix4(1,2,3,4), tdat, 0);
    chk("rst_ready0", fu_ready, 4'b0000);
    cyc(0, 4'b1111, ix4(1,2,3,4), tdat, 0);
    chk("rst_ready1", fu_ready, 4'b0000);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_we1", write_en_1, 0);
    chk("rst_we2", write_en_2, 0);

    for (int k = 0; k < 16; k++) begin
      cyc(1, tbl[k].v, tbl[k].ix, tdat, 0);
      chk($sformatf("tbl%0d_ready", k), fu_ready, tbl[k].rdy);
      chk($sformatf("tbl%0d_we1", k), write_en_1, tbl[k].we1);
      chk($sformatf("tbl%0d_idx1", k), write_idx_1, tbl[k].i1);
      chk($sformatf("tbl%0d_we2", k), write_en_2, tbl[k].we2);
      if (tbl[k].we2) chk($sformatf("tbl%0d_idx2", k), write_idx_2, tbl[k].i2);
      chk($sformatf("tbl%0d_count", k), count, tbl[k].cnt);
      check_model();
    end

    // single write, one-cycle latency
    cyc(1, 4'b0001, ix4(5,0,0,0), {96'h0, 32'hDEAD}, 0);
    chk("single_ready", fu_ready, 4'b0001);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("single_we1", write_en_1, 1);
    chk("single_idx1", write_idx_1, 5);
    chk("single_data1", write_data_1, 32'hDEAD);
    chk("single_we2", write_en_2, 0);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("single_count", count, 0);

    // steer rr_ptr back to FU0, then same-cycle coalesce: younger (FU1) wins
    cyc(1, 4'b1000, ix4(0,0,0,9), tdat, 0);
    chk("rr_ready", fu_ready, 4'b1000);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    cyc(1, 4'b0011, ix4(7,7,0,0), {64'h0, 32'h2, 32'h1}, 0);
    chk("coal_ready", fu_ready, 4'b0011);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("coal_we1", write_en_1, 1);
    chk("coal_idx1", write_idx_1, 7);
    chk("coal_data1", write_data_1, 32'h2);
    chk("coal_we2", write_en_2, 0);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);

    // flush: current drain still writes, FU2 is refused, queue empties
    cyc(1, 4'b0011, ix4(12,13,0,0), tdat, 0);
    chk("fl_pre_ready", fu_ready, 4'b0011);
    cyc(1, 4'b0100, ix4(0,0,14,0), tdat, 1);
    chk("fl_ready", fu_ready, 4'b0000);
    chk("fl_we1", write_en_1, 1);
    chk("fl_idx1", write_idx_1, 12);
    chk("fl_we2", write_en_2, 1);
    chk("fl_idx2", write_idx_2, 13);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("fl_count", count, 0);
    chk("fl_we1_after", write_en_1, 0);
    chk("fl_we2_after", write_en_2, 0);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("fl_we1_after2", write_en_1, 0);

    // reset mid-operation: pending entries never reach the ports
    cyc(1, 4'b0011, ix4(20,21,0,0), tdat, 0);
    cyc(0, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("mrst_we1", write_en_1, 0);
    chk("mrst_we2", write_en_2, 0);
    cyc(1, 4'b0000, ix4(0,0,0,0), '0, 0);
    chk("mrst_count", count, 0);
    chk("mrst_we1_after", write_en_1, 0);

    // random traffic: small index range forces collisions and r0 writes
    for (int c = 0; c < 3000; c++) begin
      logic [19:0]  rix;
      logic [127:0] rd;
      for (int f = 0; f < NUM_FU; f++) begin
        rix[f*5 +: 5]  = 5'($urandom_range(0, 3));
        rd[f*32 +: 32] = $urandom;
      end
      cyc(($urandom_range(0, 199) != 0), 4'($urandom), rix, rd, ($urandom_range(0, 19) == 0));
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
